// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one registered one-hot grant, held until done, rotating priority.
// Define RR_ARBITER_TIMEOUT_EN to build the hold counter that force-releases after MAX_HOLD cycles.
module rr_arbiter #(
  parameter int REQ_WIDTH = 16,
  parameter int MAX_HOLD  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_WIDTH-1:0]         req,
  input  logic                         done,
  output logic [REQ_WIDTH-1:0]         gnt,
  output logic                         gnt_valid,
  output logic [$clog2(REQ_WIDTH)-1:0] gnt_idx,
  output logic                         timeout
);

  localparam int IDX_W = $clog2(REQ_WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     release_ptr;
  logic [IDX_W-1:0]     search_ptr;
  logic [IDX_W-1:0]     win_idx;
  logic [REQ_WIDTH-1:0] masked_req;
  logic [REQ_WIDTH-1:0] search_req;
  logic                 any_req;
  logic                 rel;
  logic                 hold_expired;

  assign any_req = |req;

  // A release moves priority to the slot just after the current holder.
  always_comb begin
    release_ptr = '0;
    if (gnt_idx != IDX_W'(REQ_WIDTH - 1)) begin
      release_ptr = gnt_idx + 1'b1;
    end
  end

  // Search with the post-release pointer so back-to-back grants need no idle cycle.
  assign search_ptr = (state == GRANT) ? release_ptr : ptr;

  always_comb begin
    masked_req = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      masked_req[i] = req[i] && (IDX_W'(i) >= search_ptr);
    end
  end

  assign search_req = (|masked_req) ? masked_req : req;

  always_comb begin
    win_idx = '0;
    for (int i = REQ_WIDTH - 1; i >= 0; i--) begin
      if (search_req[i]) begin
        win_idx = IDX_W'(i);
      end
    end
  end

`ifdef RR_ARBITER_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt;

  assign hold_expired = (state == GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == GRANT && !rel) begin
      hold_cnt <= hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  assign rel = (state == GRANT) && (done || hold_expired);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = GRANT;
      GRANT:   if (rel && !any_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    gnt_valid = |gnt;
`ifdef RR_ARBITER_TIMEOUT_EN
    timeout   = hold_expired && !done;
`else
    timeout   = 1'b0;
`endif
  end

  // Grant and pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt     <= '0;
      gnt_idx <= '0;
      ptr     <= '0;
    end else begin
      if (rel) begin
        ptr <= release_ptr;
      end
      if ((state == IDLE || rel) && any_req) begin
        gnt     <= REQ_WIDTH'(1) << win_idx;
        gnt_idx <= win_idx;
      end else if (rel) begin
        gnt     <= '0;
        gnt_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (REQ_WIDTH=16, MAX_HOLD=8): vector table plus corner sequences.
// Honours RR_ARBITER_TIMEOUT_EN so the hold test matches the build under test.
module tb_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [15:0] gnt;
  logic        gnt_valid;
  logic [3:0]  gnt_idx;
  logic        timeout;

  int checks;
  int failures;

  typedef struct {
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  idx;
  } vec_t;

  vec_t vecs[18];

  rr_arbiter #(
    .REQ_WIDTH(16),
    .MAX_HOLD (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string name, input logic [15:0] eg, input logic [3:0] ei,
                               input logic et);
    check({name, ".gnt"}, gnt, eg);
    check({name, ".idx"}, 16'(gnt_idx), 16'(ei));
    check({name, ".valid"}, 16'(gnt_valid), 16'(|eg));
    check({name, ".timeout"}, 16'(timeout), 16'(et));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{16'h0014, 1'b0, 16'h0004, 4'd2};
    vecs[1]  = '{16'h0014, 1'b1, 16'h0010, 4'd4};
    vecs[2]  = '{16'h0014, 1'b0, 16'h0010, 4'd4};
    vecs[3]  = '{16'h0001, 1'b0, 16'h0010, 4'd4};
    vecs[4]  = '{16'h0001, 1'b1, 16'h0001, 4'd0};
    vecs[5]  = '{16'h0000, 1'b1, 16'h0000, 4'd0};
    vecs[6]  = '{16'h0000, 1'b1, 16'h0000, 4'd0};
    vecs[7]  = '{16'h0004, 1'b0, 16'h0004, 4'd2};
    vecs[8]  = '{16'h0001, 1'b0, 16'h0004, 4'd2};
    vecs[9]  = '{16'h0000, 1'b0, 16'h0004, 4'd2};
    vecs[10] = '{16'h0000, 1'b1, 16'h0000, 4'd0};
    vecs[11] = '{16'h8000, 1'b0, 16'h8000, 4'd15};
    vecs[12] = '{16'h8001, 1'b1, 16'h0001, 4'd0};
    vecs[13] = '{16'h0001, 1'b1, 16'h0001, 4'd0};
    vecs[14] = '{16'h0003, 1'b1, 16'h0002, 4'd1};
    vecs[15] = '{16'h0003, 1'b1, 16'h0001, 4'd0};
    vecs[16] = '{16'h0000, 1'b1, 16'h0000, 4'd0};
    vecs[17] = '{16'h0000, 1'b0, 16'h0000, 4'd0};

    checks   = 0;
    failures = 0;
    rst  = 1'b0;
    req  = 16'h0000;
    done = 1'b0;
    #2 rst = 1'b1;
    #1 check_outputs("reset", 16'h0000, 4'd0, 1'b0);
    step();
    step();
    rst = 1'b0;

    // Table: each row drives req/done, then the outputs after the next edge are compared.
    for (int i = 0; i < 18; i++) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      step();
      check_outputs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, 1'b0);
    end

    // Reset mid-grant drops the grant without a clock edge; pointer restarts at 0.
    req  = 16'h0011;
    done = 1'b0;
    step();
    check_outputs("pre_rst", 16'h0010, 4'd4, 1'b0);
    #2 rst = 1'b1;
    #1 check_outputs("async_rst", 16'h0000, 4'd0, 1'b0);
    step();
    rst = 1'b0;
    req = 16'h0000;
    step();
    check_outputs("post_rst_idle0", 16'h0000, 4'd0, 1'b0);
    step();
    check_outputs("post_rst_idle1", 16'h0000, 4'd0, 1'b0);
    req = 16'h0011;
    step();
    check_outputs("ptr_restart", 16'h0001, 4'd0, 1'b0);
    req = 16'h0000;
    done = 1'b1;
    step();
    check_outputs("ptr_restart_rel", 16'h0000, 4'd0, 1'b0);

    // Full rotation with all requesting and done held: 0..15 then 0, no gaps.
    pulse_reset();
    req  = 16'hFFFF;
    done = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      logic [15:0] exp_g;
      logic [3:0]  exp_i;
      step();
      exp_i = 4'(k % 16);
      exp_g = 16'h0001 << exp_i;
      check_outputs($sformatf("rot%0d", k), exp_g, exp_i, 1'b0);
    end

    // Sole requester never asserts done.
    req  = 16'h0000;
    done = 1'b0;
    pulse_reset();
    req = 16'h0002;
`ifdef RR_ARBITER_TIMEOUT_EN
    for (int c = 1; c <= 24; c++) begin
      step();
      check_outputs($sformatf("hold%0d", c), 16'h0002, 4'd1, (c % 8) == 0);
    end
`else
    for (int c = 1; c <= 100; c++) begin
      step();
      check_outputs($sformatf("hold%0d", c), 16'h0002, 4'd1, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
